// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter: FSM state encoding,
// the one-bit requester id carried through the read-tag FIFO, and default
// burst / outstanding-read limits.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   localparam int DEF_BURST_LEN = 8;
   localparam int DEF_TAG_DEPTH = 4;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle for the SDRAM port arbiter: both requester ports, the single
// controller-side user port and the sticky tag error flag.
// slave  = arbiter view, master = requesters/controller view.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              last0;
   logic              gnt0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;
   logic              rvalid0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              last1;
   logic              gnt1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;
   logic              rvalid1;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   logic              tag_err;

   modport slave (
      input  req0, we0, addr0, wdata0, last0,
      input  req1, we1, addr1, wdata1, last1,
      input  mem_ack, mem_rdata, mem_rvalid,
      output gnt0, ack0, rdata0, rvalid0,
      output gnt1, ack1, rdata1, rvalid1,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output tag_err
   );

   modport master (
      output req0, we0, addr0, wdata0, last0,
      output req1, we1, addr1, wdata1, last1,
      output mem_ack, mem_rdata, mem_rvalid,
      input  gnt0, ack0, rdata0, rvalid0,
      input  gnt1, ack1, rdata1, rvalid1,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  tag_err
   );

endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester ids for outstanding reads. A push and a pop in
// the same cycle both take effect, so a full FIFO can accept a push while
// it is being popped.
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = DEF_TAG_DEPTH
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  port_id_t pushData_i,
   input  logic     pop_i,
   output port_id_t popData_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   port_id_t          store_q [DEPTH];
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              doPush;
   logic              doPop;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign popData_o = store_q[rdPtr_q];
   assign doPop     = pop_i & ~empty_o;
   assign doPush    = push_i & (~full_o | doPop);

   // Advance pointers with explicit wrap and track occupancy.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      end
      if (doPop) begin
         rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset forgets everything outstanding.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Tag storage needs no reset; only slots below the count are ever read.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         store_q[wrPtr_q] <= pushData_i;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter for the SDRAM user port. Port 0 is the Nios single-word
// path, port 1 the camera/filter burst path. Ownership is granted per burst
// (capped at BURST_LEN beats) and read returns are steered back to the
// issuing port through an in-order tag FIFO.
// Build option: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break;
// otherwise port 0 wins every tie.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int ADDR_W    = 22,
   parameter int DATA_W    = 32,
   parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   sdram_port_arbiter_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_OWN0 = OWN0;
   localparam logic [1:0] ST_OWN1 = OWN1;
   localparam int         CNT_W   = $clog2(BURST_LEN + 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  beatCnt_q, beatCnt_d;
   logic [CNT_W-1:0]  beatInc;

   logic              ownReq;
   logic              ownWe;
   logic [ADDR_W-1:0] ownAddr;
   logic [DATA_W-1:0] ownWdata;
   logic              ownLast;
   port_id_t          ownId;

   logic              memReq;
   logic              accept;
   port_id_t          winner;

   logic              tagFull;
   logic              tagEmpty;
   logic              tagPush;
   logic              tagPop;
   port_id_t          tagPopId;

   logic              rvalid0_q, rvalid1_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic              tagErr_q;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   port_id_t          lastServed_q, lastServed_d;
`endif

   // Select the current owner's request fields; all zero while idle.
   always_comb begin
      ownReq   = 1'b0;
      ownWe    = 1'b0;
      ownAddr  = '0;
      ownWdata = '0;
      ownLast  = 1'b0;
      ownId    = PORT0;
      case (state_q)
         ST_OWN0: begin
            ownReq   = bus.req0;
            ownWe    = bus.we0;
            ownAddr  = bus.addr0;
            ownWdata = bus.wdata0;
            ownLast  = bus.last0;
            ownId    = PORT0;
         end
         ST_OWN1: begin
            ownReq   = bus.req1;
            ownWe    = bus.we1;
            ownAddr  = bus.addr1;
            ownWdata = bus.wdata1;
            ownLast  = bus.last1;
            ownId    = PORT1;
         end
         default: begin
         end
      endcase
   end

   // A read is held off while the tag FIFO cannot record its owner.
   assign memReq  = ownReq & ~(~ownWe & tagFull);
   assign accept  = memReq & bus.mem_ack;
   assign beatInc = beatCnt_q + 1'b1;

   assign bus.mem_req   = memReq;
   assign bus.mem_we    = ownWe;
   assign bus.mem_addr  = ownAddr;
   assign bus.mem_wdata = ownWdata;
   assign bus.gnt0      = (state_q == ST_OWN0);
   assign bus.gnt1      = (state_q == ST_OWN1);
   assign bus.ack0      = accept & (state_q == ST_OWN0);
   assign bus.ack1      = accept & (state_q == ST_OWN1);
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.tag_err   = tagErr_q;

   // Pick the idle-state winner when both ports request together.
   always_comb begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      if (bus.req0 && bus.req1) begin
         winner = (lastServed_q == PORT0) ? PORT1 : PORT0;
      end else begin
         winner = bus.req1 ? PORT1 : PORT0;
      end
`else
      winner = bus.req0 ? PORT0 : PORT1;
`endif
   end

   // Ownership FSM: grant per burst, release on last, cap, or dropped request.
   always_comb begin
      state_d   = state_q;
      beatCnt_d = beatCnt_q;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      lastServed_d = lastServed_q;
`endif
      if (state_q == ST_IDLE) begin
         beatCnt_d = '0;
         if (bus.req0 || bus.req1) begin
            state_d = (winner == PORT1) ? ST_OWN1 : ST_OWN0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            lastServed_d = winner;
`endif
         end
      end else begin
         if (accept) begin
            beatCnt_d = beatInc;
            if (ownLast || (beatInc == CNT_W'(BURST_LEN))) begin
               state_d = ST_IDLE;
            end
         end else if (!ownReq) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Every accepted read records its owner; every return pops one entry.
   assign tagPush = accept & ~ownWe;
   assign tagPop  = bus.mem_rvalid & ~tagEmpty;

   sdram_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tagFifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (tagPush),
      .pushData_i (ownId),
      .pop_i      (tagPop),
      .popData_o  (tagPopId),
      .full_o     (tagFull),
      .empty_o    (tagEmpty)
   );

   // State, beat counter and the registered read-return path.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         beatCnt_q <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         tagErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         beatCnt_q <= beatCnt_d;
         rvalid0_q <= tagPop & (tagPopId == PORT0);
         rvalid1_q <= tagPop & (tagPopId == PORT1);
         if (tagPop && (tagPopId == PORT0)) begin
            rdata0_q <= bus.mem_rdata;
         end
         if (tagPop && (tagPopId == PORT1)) begin
            rdata1_q <= bus.mem_rdata;
         end
         tagErr_q  <= tagErr_q | (bus.mem_rvalid & tagEmpty);
      end
   end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   // Remember which port was granted last for the next tie-break.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lastServed_q <= PORT1;
      end else begin
         lastServed_q <= lastServed_d;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (BURST_LEN=8,
// TAG_DEPTH=4). Grant-order expectations follow SDRAM_ARB_ROUND_ROBIN_EN.
module tb_sdram_port_arbiter;

   logic clk;
   logic rst;
   int   checkCount;
   int   passCount;

   sdram_port_arbiter_if #(.ADDR_W(22), .DATA_W(32)) bus ();

   sdram_port_arbiter #(
      .BURST_LEN (8),
      .ADDR_W    (22),
      .DATA_W    (32),
      .TAG_DEPTH (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int port, input logic req, input logic we,
                                input logic [21:0] addr, input logic [31:0] wdata,
                                input logic last);
      if (port == 0) begin
         bus.req0 = req; bus.we0 = we; bus.addr0 = addr;
         bus.wdata0 = wdata; bus.last0 = last;
      end else begin
         bus.req1 = req; bus.we1 = we; bus.addr1 = addr;
         bus.wdata1 = wdata; bus.last1 = last;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   logic [1:0] expTrace [16];
   int         owner;
   int         b0, b1;
   int         ack1Count;

   // Directed test sequence.
   initial begin
      checkCount = 0;
      passCount  = 0;
      rst = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; bus.mem_rvalid = 1'b0;
      step(); step();

      $display("[TB] reset values");
      checkOutput("rst_gnt0",    64'(bus.gnt0),      64'h0);
      checkOutput("rst_gnt1",    64'(bus.gnt1),      64'h0);
      checkOutput("rst_ack",     64'({bus.ack0, bus.ack1}), 64'h0);
      checkOutput("rst_rvalid",  64'({bus.rvalid0, bus.rvalid1}), 64'h0);
      checkOutput("rst_rdata0",  64'(bus.rdata0),    64'h0);
      checkOutput("rst_rdata1",  64'(bus.rdata1),    64'h0);
      checkOutput("rst_mem_req", 64'(bus.mem_req),   64'h0);
      checkOutput("rst_mem_fld", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'h0);
      checkOutput("rst_tag_err", 64'(bus.tag_err),   64'h0);
      rst = 1'b0;

      $display("[TB] single port 0 read");
      step();
      applyStimulus(0, 1'b1, 1'b0, 22'h123, 32'h0, 1'b1);
      bus.mem_ack = 1'b1;
      settle();
      checkOutput("t2_gnt0_t", 64'(bus.gnt0), 64'h0);
      step(); settle();
      checkOutput("t2_gnt0_t1",  64'(bus.gnt0),     64'h1);
      checkOutput("t2_ack0_t1",  64'(bus.ack0),     64'h1);
      checkOutput("t2_memreq",   64'(bus.mem_req),  64'h1);
      checkOutput("t2_memaddr",  64'(bus.mem_addr), 64'h123);
      checkOutput("t2_memwe",    64'(bus.mem_we),   64'h0);
      step();
      applyStimulus(0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      settle();
      checkOutput("t2_release", 64'(bus.gnt0), 64'h0);
      step(); step(); step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      settle();
      checkOutput("t2_rvalid0_t5", 64'(bus.rvalid0), 64'h0);
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      checkOutput("t2_rvalid0_t6", 64'(bus.rvalid0), 64'h1);
      checkOutput("t2_rdata0_t6",  64'(bus.rdata0),  64'hDEADBEEF);
      checkOutput("t2_rvalid1_t6", 64'(bus.rvalid1), 64'h0);

      $display("[TB] two 3-beat bursts contending");
      resetDut();
      for (int i = 0; i < 16; i++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         expTrace[i] = (i % 4 == 0) ? 2'd2 : ((i / 8 == (i % 8) / 4) ? 2'd0 : 2'd1);
`else
         expTrace[i] = (i % 4 == 0) ? 2'd2 : 2'd0;
`endif
      end
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      expTrace[1] = 2'd0; expTrace[2] = 2'd0; expTrace[3] = 2'd0;
      expTrace[5] = 2'd1; expTrace[6] = 2'd1; expTrace[7] = 2'd1;
      expTrace[9] = 2'd0; expTrace[10] = 2'd0; expTrace[11] = 2'd0;
      expTrace[13] = 2'd1; expTrace[14] = 2'd1; expTrace[15] = 2'd1;
`endif
      applyStimulus(0, 1'b1, 1'b1, 22'h010, 32'h0000A000, 1'b0);
      applyStimulus(1, 1'b1, 1'b1, 22'h020, 32'h0000B000, 1'b0);
      b0 = 0; b1 = 0;
      for (int i = 0; i < 16; i++) begin
         bus.last0 = (b0 == 2);
         bus.last1 = (b1 == 2);
         settle();
         owner = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : 2);
         checkOutput($sformatf("t3_owner_c%0d", i), 64'(owner), 64'(expTrace[i]));
         if (bus.ack0) b0 = (b0 == 2) ? 0 : b0 + 1;
         if (bus.ack1) b1 = (b1 == 2) ? 0 : b1 + 1;
         step();
      end
      applyStimulus(0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      settle();
      checkOutput("t3_idle_after", 64'({bus.gnt0, bus.gnt1}), 64'h0);

      $display("[TB] port 1 stream capped at BURST_LEN");
      step();
      applyStimulus(1, 1'b1, 1'b1, 22'h2AA, 32'h11112222, 1'b0);
      settle();
      ack1Count = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 1) applyStimulus(0, 1'b1, 1'b1, 22'h055, 32'h33334444, 1'b1);
         settle();
         if (i == 1) begin
            checkOutput("t4_memaddr",  64'(bus.mem_addr),  64'h2AA);
            checkOutput("t4_memwdata", 64'(bus.mem_wdata), 64'h11112222);
            checkOutput("t4_memwe",    64'(bus.mem_we),    64'h1);
         end
         if (bus.ack1) ack1Count++;
         if (i == 8) checkOutput("t4_gnt1_beat8", 64'(bus.gnt1), 64'h1);
         if (i == 9) checkOutput("t4_bubble", 64'({bus.gnt0, bus.gnt1}), 64'h0);
         if (i == 10) begin
            checkOutput("t4_gnt0_next", 64'(bus.gnt0), 64'h1);
            checkOutput("t4_ack0_next", 64'(bus.ack0), 64'h1);
         end
      end
      checkOutput("t4_ack1_count", 64'(ack1Count), 64'd8);
      step();
      applyStimulus(0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);

      $display("[TB] tag FIFO full back-pressure");
      step();
      applyStimulus(0, 1'b1, 1'b0, 22'h100, 32'h0, 1'b0);
      settle();
      for (int i = 1; i <= 4; i++) begin
         step(); settle();
         checkOutput($sformatf("t5_ack0_r%0d", i), 64'(bus.ack0), 64'h1);
      end
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A50001;
      settle();
      checkOutput("t5_full_memreq", 64'(bus.mem_req), 64'h0);
      checkOutput("t5_full_gnt0",   64'(bus.gnt0),    64'h1);
      step();
      bus.mem_rvalid = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 22'h104, 32'h0, 1'b1);
      settle();
      checkOutput("t5_fifth_ack0", 64'(bus.ack0),    64'h1);
      checkOutput("t5_ret_rvalid", 64'(bus.rvalid0), 64'h1);
      checkOutput("t5_ret_rdata",  64'(bus.rdata0),  64'hA5A50001);
      step();
      applyStimulus(0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000B000 + 32'(i);
         step(); settle();
         checkOutput($sformatf("t5_drain_rv%0d", i), 64'(bus.rvalid0), 64'h1);
         checkOutput($sformatf("t5_drain_rd%0d", i), 64'(bus.rdata0),
                     64'h0000B000 + 64'(i));
      end
      bus.mem_rvalid = 1'b0;
      step(); settle();
      checkOutput("t5_no_tag_err", 64'(bus.tag_err), 64'h0);

      $display("[TB] interleaved returns");
      applyStimulus(0, 1'b1, 1'b0, 22'h200, 32'h0, 1'b1);
      step(); settle();
      checkOutput("t6_ack0_a", 64'(bus.ack0), 64'h1);
      step();
      applyStimulus(0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      applyStimulus(1, 1'b1, 1'b0, 22'h300, 32'h0, 1'b1);
      settle();
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC0C00000;
      settle();
      checkOutput("t6_ack1_b", 64'({bus.gnt1, bus.ack1}), 64'h3);
      step();
      bus.mem_rvalid = 1'b0;
      applyStimulus(1, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      applyStimulus(0, 1'b1, 1'b0, 22'h204, 32'h0, 1'b1);
      settle();
      checkOutput("t6_ret0_valid", 64'({bus.rvalid0, bus.rvalid1}), 64'h2);
      checkOutput("t6_ret0_data",  64'(bus.rdata0), 64'hC0C00000);
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC1C10001;
      settle();
      checkOutput("t6_ack0_c", 64'(bus.ack0), 64'h1);
      step();
      bus.mem_rdata = 32'hC2C20002;
      applyStimulus(0, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      settle();
      checkOutput("t6_ret1_valid", 64'({bus.rvalid0, bus.rvalid1}), 64'h1);
      checkOutput("t6_ret1_data",  64'(bus.rdata1), 64'hC1C10001);
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      checkOutput("t6_ret2_valid", 64'({bus.rvalid0, bus.rvalid1}), 64'h2);
      checkOutput("t6_ret2_data",  64'(bus.rdata0), 64'hC2C20002);

      $display("[TB] spurious return and mid-burst reset");
      resetDut();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000BAD;
      settle();
      checkOutput("t7_tag_err_pre", 64'(bus.tag_err), 64'h0);
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      checkOutput("t7_tag_err_set", 64'(bus.tag_err), 64'h1);
      checkOutput("t7_no_rvalid",   64'({bus.rvalid0, bus.rvalid1}), 64'h0);
      applyStimulus(1, 1'b1, 1'b1, 22'h3FF, 32'h0000FFFF, 1'b0);
      step(); settle();
      checkOutput("t7_gnt1_burst", 64'(bus.gnt1), 64'h1);
      resetDut();
      applyStimulus(1, 1'b0, 1'b0, 22'h0, 32'h0, 1'b0);
      settle();
      checkOutput("t7_rst_gnt",     64'({bus.gnt0, bus.gnt1}), 64'h0);
      checkOutput("t7_rst_ack",     64'({bus.ack0, bus.ack1}), 64'h0);
      checkOutput("t7_rst_memreq",  64'(bus.mem_req),  64'h0);
      checkOutput("t7_rst_memfld",  64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'h0);
      checkOutput("t7_rst_tag_err", 64'(bus.tag_err),  64'h0);
      checkOutput("t7_rst_rdata0",  64'(bus.rdata0),   64'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM user port between two requesters: port 0 is the Nios image-line path (single-word reads/writes), port 1 is the camera/filter streaming path (bursts). Ownership is granted per burst, capped at BURST_LEN beats. Read returns are steered back to the issuing port through a small in-order tag FIFO. Sits between the Nios/filter datapath and the SDRAM controller FIFOs.

## Interface
- BURST_LEN, 8: maximum accepted beats per ownership grant (2..64)
- ADDR_W, 22: SDRAM word address width
- DATA_W, 32: beat data width
- TAG_DEPTH, 4: maximum outstanding reads (power of 2)
- Clock  in  1  sole clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- reqN  in  1  port N (N=0,1) wants a beat; held until accepted
- weN  in  1  1 = write beat, 0 = read beat
- addrN  in  ADDR_W  beat address
- wdataN  in  DATA_W  write data
- lastN  in  1  final beat of requester's burst
- gntN  out  1  port N owns the SDRAM port
- ackN  out  1  port N beat accepted this cycle
- rdataN  out  DATA_W  read data for port N
- rvalidN  out  1  rdataN valid, one-cycle pulse
- mem_req  out  1  beat presented to controller
- mem_we / mem_addr / mem_wdata  out  1/ADDR_W/DATA_W  beat fields, muxed from owner
- mem_ack  in  1  controller accepts the beat this cycle
- mem_rdata  in  DATA_W  returned read data, in issue order
- mem_rvalid  in  1  mem_rdata valid
- tag_err  out  1  sticky: mem_rvalid seen with tag FIFO empty

## Operation
- States: IDLE, OWN0, OWN1.
- IDLE: if any reqN, register a winner and move to OWNwinner; otherwise stay. Winner selection is set by the Configuration macro.
- OWNx: gntx=1; mem_req = reqx AND NOT (wex=0 AND tag FIFO full); mem fields = port x fields.
- Beat accept: mem_req & mem_ack. Then ackx=1 and the beat counter increments.
- An accepted read pushes x into the tag FIFO.
- Return to IDLE on any of:
  - accepted beat with lastx=1
  - accepted beat that brings the beat count to BURST_LEN
  - reqx=0 while no beat is pending
- Beat counter clears on entry to OWNx.
- Return path: each mem_rvalid pops the tag FIFO and drives rdata/rvalid of the popped port. The other port's rvalid stays 0.
- Return path is independent of ownership; returns may arrive during another port's grant.
- Simultaneous push and pop: both occur; occupancy is unchanged; a full FIFO accepts the push in the same cycle as the pop.
- mem_rvalid with FIFO empty: no rvalid pulse, data dropped, tag_err set until Reset.
- Reset at any time: state→IDLE, FIFO emptied, counter cleared, outstanding reads forgotten.

## Timing
- Reset values: gnt0/1=0, ack0/1=0, rvalid0/1=0, rdata0/1=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, tag_err=0.
- Grant latency: reqN seen in IDLE at cycle t → gntN=1 at t+1. First beat can be accepted at t+1.
- mem_req, mem fields and ackN are combinational from the state and owner inputs. No extra register stage.
- Release: the state is IDLE in the cycle after the releasing beat, giving a one-cycle bubble between owners.
- Read return: rvalidN is registered, one cycle after mem_rvalid; rdataN is registered alongside it.
- Back-to-back beats are allowed every cycle while mem_ack=1.

## Configuration
- SDRAM_ARB_ROUND_ROBIN_EN defined: in IDLE with both requesting, grant goes to the port not served last. The last-served register resets to port 1, so port 0 wins first.
- Undefined: fixed priority; port 0 (Nios) always wins a tie.

## Structure
- Package sdram_arb_pkg holds:
  - arb_state_t enum (IDLE, OWN0, OWN1)
  - port_id_t (1 bit)
  - default constants for BURST_LEN and TAG_DEPTH
- Sub-module sdram_arb_tag_fifo: synchronous FIFO of port_id_t, depth TAG_DEPTH, with full/empty flags. Supports simultaneous push and pop.

## Test plan
- Single requester, port 0 read, mem_ack=1: gnt0 at t+1, ack0 at t+1. Return mem_rvalid at t+5 → rvalid0 at t+6 with data; rvalid1 stays 0.
- Both request in the same cycle, each 3-beat bursts, ROUND_ROBIN_EN defined:
  - Grant order is 0, 1, 0, 1.
  - Each grant ends on lastN.
  - One IDLE cycle separates grants.
  - Undefined macro: port 0 is regranted continuously while it requests.
- Port 1 streams 20 writes with no last, BURST_LEN=8, port 0 requesting: port 1 is released after 8 beats. Port 0 is granted next under round-robin.
- Five reads issued with no returns, TAG_DEPTH=4: four are acked, then mem_req=0. The fifth is acked the cycle after the first mem_rvalid.
- Interleaved returns: port 0 and port 1 reads alternate. Returns route to the issuing port in order, including a return that arrives while the other port holds the grant.
- Spurious mem_rvalid after Reset → tag_err=1, no rvalid. Reset asserted mid-burst → all outputs zero the next cycle, and tag_err clears.
